mem_stage_sram_ctrl: RTL and testbench

//  MEM-stage data-memory controller of the MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register.
//  It turns a 32-bit load/store (MEM_R_En/MEM_W_En, ALU_result address) into two 16-bit accesses to the external SRAM.
//  It returns the loaded word on Mem_Data, which the MEM/WB register captures.
//  It drives 'ready' low while an access is in flight; the hazard/freeze logic stalls every pipeline register on !ready.

---
 rtl/mem_stage_sram_ctrl.sv | 108 ++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits a 32-bit load/store into two
// 16-bit SRAM accesses and stalls the pipeline through 'ready' while busy.
module mem_stage_sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_En,
    input  logic               MEM_W_En,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic               ready,
    output logic [31:0]        Mem_Data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic [SRAM_AW-1:0] addr_lo, addr_hi;
    logic               phase_end;
    logic               dq_oe;
    logic [15:0]        dq_out;

    // Word address doubled == byte offset >> 1 with bit 0 cleared; wraps silently.
    assign addr_lo   = SRAM_AW'((ALU_result - 32'(ADDR_BASE)) >> 1) & ~SRAM_AW'(1);
    assign addr_hi   = addr_lo | SRAM_AW'(1);
    assign phase_end = (cnt_q == CW'(WAIT_CYCLES));

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign Mem_Data  = mem_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        mem_data_d = mem_data_q;
        ready      = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_CE_N  = 1'b1;
        dq_oe      = 1'b0;
        dq_out     = '0;
        case (state_q)
            IDLE: begin
                ready = !MEM_R_En && !MEM_W_En;
                if (MEM_R_En)      state_d = RD_LO;
                else if (MEM_W_En) state_d = WR_LO;
            end
            RD_LO, RD_HI: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_ADDR = (state_q == RD_LO) ? addr_lo : addr_hi;
                if (phase_end) begin
                    if (state_q == RD_LO) begin
                        mem_data_d[15:0] = SRAM_DQ;
                        state_d          = RD_HI;
                    end else begin
                        mem_data_d[31:16] = SRAM_DQ;
                        state_d           = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_LO, WR_HI: begin
                SRAM_CE_N = 1'b0;
                SRAM_ADDR = (state_q == WR_LO) ? addr_lo : addr_hi;
                dq_oe     = 1'b1;
                dq_out    = (state_q == WR_LO) ? ST_val[15:0] : ST_val[31:16];
                // Strobe released in the last cycle so address/data are held past WE_N rise.
                SRAM_WE_N = phase_end;
                if (phase_end) state_d = (state_q == WR_LO) ? WR_HI : DONE;
                else           cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
        end
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: SRAM device model, per-access timeline model
// checked every cycle, plus directed load/store scenarios with literal results.
module tb_mem_stage_sram_ctrl;
    localparam int W  = 1;
    localparam int AW = 18;

    logic          clk, rst;
    logic          MEM_R_En, MEM_W_En;
    logic [31:0]   ALU_result, ST_val;
    logic          ready;
    logic [31:0]   Mem_Data;
    logic [AW-1:0] SRAM_ADDR;
    wire  [15:0]   SRAM_DQ;
    logic          SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .MEM_R_En(MEM_R_En), .MEM_W_En(MEM_W_En),
        .ALU_result(ALU_result), .ST_val(ST_val), .ready(ready), .Mem_Data(Mem_Data),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // SRAM device: drives on read, writes on every clock with WE_N low.
    logic [15:0] dev [0:(1<<AW)-1];
    int          we_lows = 0;
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? dev[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            dev[SRAM_ADDR] <= SRAM_DQ;
            we_lows        <= we_lows + 1;
        end
    end

    // Timeline model: an access occupies cycles k=0..2W+3 after the request is
    // first seen; k=1..W+1 low half, W+2..2W+2 high half, 2W+3 completion.
    logic [15:0] mm [0:(1<<AW)-1];
    bit          chk_en = 0;
    bit          m_busy = 0, m_rd = 0, hi = 0;
    int          m_k = 0, j = 0;
    logic [31:0] m_wa = 0, m_st = 0, m_data = 0;
    logic [AW-1:0] ea = 0;
    logic [15:0] half = 0;

    always @(negedge clk) begin
        if (m_busy && m_k <= 2*W+2) begin
            hi   = (m_k > W+1);
            j    = hi ? m_k - W - 2 : m_k - 1;
            ea   = AW'((m_wa << 1) | {31'b0, hi});
            half = hi ? m_st[31:16] : m_st[15:0];
        end
        if (chk_en) begin
            if (m_busy && m_k <= 2*W+2) begin
                check("busy_ready", {31'b0, ready}, 32'd0);
                check("busy_ce_n", {31'b0, SRAM_CE_N}, 32'd0);
                check("busy_addr", {14'b0, SRAM_ADDR}, {14'b0, ea});
                check("busy_oe_n", {31'b0, SRAM_OE_N}, m_rd ? 32'd0 : 32'd1);
                check("busy_we_n", {31'b0, SRAM_WE_N}, (m_rd || j == W) ? 32'd1 : 32'd0);
                check("busy_dq", {16'b0, SRAM_DQ}, {16'b0, m_rd ? mm[ea] : half});
            end else begin
                check("idle_ready", {31'b0, ready},
                      m_busy ? 32'd1 : {31'b0, !MEM_R_En && !MEM_W_En});
                check("idle_ctl", {29'b0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
                check("idle_addr", {14'b0, SRAM_ADDR}, 32'd0);
            end
            check("mem_data", Mem_Data, m_data);
        end
        if (rst) begin
            m_busy = 0;
            m_data = 0;
        end else if (!m_busy) begin
            if (MEM_R_En || MEM_W_En) begin
                m_busy = 1;
                m_k    = 1;
                m_rd   = MEM_R_En;
                m_wa   = (ALU_result - 32'd1024) >> 2;
                m_st   = ST_val;
            end
        end else if (m_k == 2*W+3) begin
            m_busy = 0;
        end else begin
            if (j == W) begin
                if (m_rd) begin
                    if (hi) m_data[31:16] = mm[ea];
                    else    m_data[15:0]  = mm[ea];
                end else begin
                    mm[ea] = half;
                end
            end
            m_k++;
        end
    end

    // Present a request just after a clock edge and hold it until ready.
    task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output int lows, output logic [31:0] md);
        MEM_R_En = r; MEM_W_En = w; ALU_result = a; ST_val = d;
        lows = 0; md = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready) break;
            lows++;
        end
        check("op_completes", {31'b0, ready}, 32'd1);
        md = Mem_Data;
        @(posedge clk); #1;
        MEM_R_En = 0; MEM_W_En = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          lows, we0;
    logic [31:0] md;

    initial begin
        for (int i = 0; i < 8; i++) begin
            dev[i] = 16'h1100 + 16'(i);
            mm[i]  = 16'h1100 + 16'(i);
        end
        rst = 1; MEM_R_En = 0; MEM_W_En = 0; ALU_result = 0; ST_val = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0; chk_en = 1;

        // 1: idle after reset
        repeat (4) @(negedge clk);
        check("t1_ready", {31'b0, ready}, 32'd1);
        check("t1_mem_data", Mem_Data, 32'd0);
        check("t1_ctl", {29'b0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
        @(posedge clk); #1;

        // 2: store DEADBEEF @1024
        we0 = we_lows;
        op(0, 1, 32'd1024, 32'hDEADBEEF, lows, md);
        check("t2_lows", lows, 32'd5);
        check("t2_we_pulses", we_lows - we0, 32'd2);
        check("t2_sram0", {16'b0, dev[0]}, 32'h0000BEEF);
        check("t2_sram1", {16'b0, dev[1]}, 32'h0000DEAD);

        // 3: load back
        op(1, 0, 32'd1024, 32'h0, lows, md);
        check("t3_lows", lows, 32'd5);
        check("t3_data", md, 32'hDEADBEEF);

        // 4: store then immediate load @1028
        we0 = we_lows;
        op(0, 1, 32'd1028, 32'h12345678, lows, md);
        op(1, 0, 32'd1028, 32'h0, lows, md);
        check("t4_data", md, 32'h12345678);
        check("t4_sram2", {16'b0, dev[2]}, 32'h00005678);
        check("t4_sram3", {16'b0, dev[3]}, 32'h00001234);
        check("t4_we_pulses", we_lows - we0, 32'd2);

        // 5: read and write both requested -> read only
        we0 = we_lows;
        op(1, 1, 32'd1024, 32'hCAFEF00D, lows, md);
        check("t5_data", md, 32'hDEADBEEF);
        check("t5_we_pulses", we_lows - we0, 32'd0);
        check("t5_sram0", {16'b0, dev[0]}, 32'h0000BEEF);
        check("t5_sram1", {16'b0, dev[1]}, 32'h0000DEAD);

        // address mapping away from the base: byte 0x500 -> half-words 0x80/0x81
        op(0, 1, 32'h500, 32'hA5A50F0F, lows, md);
        check("map_lo", {16'b0, dev[18'h80]}, 32'h00000F0F);
        check("map_hi", {16'b0, dev[18'h81]}, 32'h0000A5A5);

        // 6: reset during RD_HI, then reissue
        MEM_R_En = 1; ALU_result = 32'd1028;
        repeat (3) @(posedge clk);
        #1 rst = 1; MEM_R_En = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t6_mem_data", Mem_Data, 32'd0);
        check("t6_ce_n", {31'b0, SRAM_CE_N}, 32'd1);
        check("t6_ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        op(1, 0, 32'd1028, 32'h0, lows, md);
        check("t6_reload", md, 32'h12345678);
        check("t6_lows", lows, 32'd5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
